// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready flow control, bubble insertion,
// synchronous flush and an optional two-entry skid buffer (SKID=1).
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bubble,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid, m_valid_d;
  logic [DATA_W-1:0] m_data,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl,  m_ctrl_d;
  logic              s_valid, s_valid_d;
  logic [DATA_W-1:0] s_data,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl,  s_ctrl_d;

  logic              accept;
  logic              issue;
  logic [CTRL_W-1:0] in_ctrl_eff;

  // Skid mode keeps in_ready a pure register output; single-entry mode passes out_ready through.
  assign in_ready    = (SKID == 0) ? (~m_valid | out_ready) : ~s_valid;
  assign accept      = in_valid & in_ready;
  assign issue       = m_valid & out_ready;
  assign in_ctrl_eff = in_bubble ? '0 : in_ctrl;

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  // Next-state for main (M) and skid (S) entries; flush wins over any handshake.
  always_comb begin
    m_valid_d = m_valid;
    m_data_d  = m_data;
    m_ctrl_d  = m_ctrl;
    s_valid_d = s_valid;
    s_data_d  = s_data;
    s_ctrl_d  = s_ctrl;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (SKID == 0) begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl_eff;
      end else if (issue) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else begin
      if (!m_valid || issue) begin
        if (s_valid) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_ctrl_d  = s_ctrl;
          s_valid_d = 1'b0;
          s_ctrl_d  = '0;
          if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
            s_ctrl_d  = in_ctrl_eff;
          end
        end else if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
          m_ctrl_d  = in_ctrl_eff;
        end else begin
          m_valid_d = 1'b0;
          m_ctrl_d  = '0;
        end
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
        s_ctrl_d  = in_ctrl_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
    end else begin
      m_valid <= m_valid_d;
      m_data  <= m_data_d;
      m_ctrl  <= m_ctrl_d;
      s_valid <= s_valid_d;
      s_data  <= s_data_d;
      s_ctrl  <= s_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share
// stimulus and are each compared against a FIFO-queue reference model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bubble = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_ready = 1'b0;

  logic          rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;

  entry_t q1[$];
  entry_t q0[$];
  int     n_total = 0;
  int     n_pass  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_bubble(in_bubble), .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1), .occupancy(occ1));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_bubble(in_bubble), .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0), .occupancy(occ0));

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic exp_rdy1();
    return q1.size() < 2;
  endfunction

  function automatic logic exp_rdy0();
    return (q0.size() == 0) || out_ready;
  endfunction

  task automatic check_outputs();
    check("s1_in_ready", DW'(rdy1), DW'(exp_rdy1()));
    check("s1_out_valid", DW'(ov1), DW'(q1.size() != 0));
    check("s1_occupancy", DW'(occ1), DW'(q1.size()));
    check("s1_out_ctrl", DW'(oc1), (q1.size() != 0) ? DW'(q1[0].c) : '0);
    if (q1.size() != 0) check("s1_out_data", od1, q1[0].d);
    check("s0_in_ready", DW'(rdy0), DW'(exp_rdy0()));
    check("s0_out_valid", DW'(ov0), DW'(q0.size() != 0));
    check("s0_occupancy", DW'(occ0), DW'(q0.size()));
    check("s0_out_ctrl", DW'(oc0), (q0.size() != 0) ? DW'(q0[0].c) : '0);
    if (q0.size() != 0) check("s0_out_data", od0, q0[0].d);
  endtask

  // Apply one cycle of stimulus: check at the negedge, advance models at the posedge.
  task automatic cyc(input logic iv, input logic ib, input logic fl, input logic ordy,
                     input logic [DW-1:0] d, input logic [CW-1:0] c);
    logic   acc1, acc0, iss1, iss0;
    entry_t e;
    in_valid = iv; in_bubble = ib; flush = fl; out_ready = ordy; in_data = d; in_ctrl = c;
    @(negedge clk);
    check_outputs();
    acc1 = iv && exp_rdy1();
    acc0 = iv && exp_rdy0();
    iss1 = (q1.size() != 0) && ordy;
    iss0 = (q0.size() != 0) && ordy;
    e.d = d;
    e.c = ib ? '0 : c;
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (iss1) void'(q1.pop_front());
      if (acc1) q1.push_back(e);
      if (iss0) void'(q0.pop_front());
      if (acc0) q0.push_back(e);
    end
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #12;
    check("rst_out_valid", DW'(ov1), '0);
    check("rst_out_data", od1, '0);
    check("rst_out_ctrl", DW'(oc1), '0);
    check("rst_occupancy", DW'(occ1), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, DW'(i), 8'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Skid fill, stall, drain
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hA), 8'h11);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hB), 8'h22);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hEE), 8'h33);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Bubble
    cyc(1'b1, 1'b1, 1'b0, 1'b0, DW'(128'h1234), 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Flush at occupancy 2 with a simultaneous input C
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hA1), 8'h01);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hB2), 8'h02);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(128'hC3), 8'h03);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) != 0),
          rnd_data(), 8'($urandom()));

    // Asynchronous reset with the skid buffer full
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hD1), 8'h44);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hD2), 8'h55);
    in_valid = 1'b0;
    check("pre_rst_occupancy", DW'(occ1), DW'(q1.size()));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", DW'(ov1), '0);
    check("mid_rst_out_ctrl", DW'(oc1), '0);
    check("mid_rst_occupancy", DW'(occ1), '0);
    check("mid_rst_s0_valid", DW'(ov0), '0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", DW'(rdy1), 128'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, rnd_data(), 8'($urandom()));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
